// File: rtl/detect_errors.sv
// Receive-side frame-loss checker: counts frames per aux tag group and judges
// each group complete (ok) or short (ng), accumulating missing-frame totals.
module detect_errors #(
  parameter int whereis_aux = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] segment_number_max,
  input  logic        rx_en,
  input  logic [7:0]  rx_data,
  output logic [31:0] count,
  output logic [31:0] ok,
  output logic [31:0] ng,
  output logic [31:0] lostnum,
  output logic        valid,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    CHECK = 3'd2,
    JUDGE = 3'd3
  } state_t;

  localparam logic [15:0] AUX_IDX = 16'(whereis_aux);

  state_t      state_q;
  logic [15:0] byteCnt_q;
  logic [7:0]  aux_q;
  logic [7:0]  curAux_q;
  logic [15:0] segCnt_q;
  logic        groupOpen_q;
  logic        haveGroup_q;
  logic        judgeChange_q;
  logic        skip_q;
  logic [31:0] count_q;
  logic [31:0] ok_q;
  logic [31:0] ng_q;
  logic [31:0] lostnum_q;
  logic        valid_q;

  logic [15:0] maxEff;
  logic [15:0] segInc;
  logic [15:0] lostInc;
  logic        sameAux;

  always_comb begin
    maxEff  = (segment_number_max == 16'd0) ? 16'd1 : segment_number_max;
    segInc  = segCnt_q + 16'd1;
    lostInc = maxEff - segCnt_q;
    sameAux = (aux_q == curAux_q);
  end

  // skip_q is set by reset so the tail of an interrupted frame is ignored
  // until rx_en has been seen low once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      byteCnt_q     <= 16'd0;
      aux_q         <= 8'd0;
      curAux_q      <= 8'd0;
      segCnt_q      <= 16'd0;
      groupOpen_q   <= 1'b0;
      haveGroup_q   <= 1'b0;
      judgeChange_q <= 1'b0;
      skip_q        <= 1'b1;
      count_q       <= 32'd0;
      ok_q          <= 32'd0;
      ng_q          <= 32'd0;
      lostnum_q     <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          skip_q <= skip_q & rx_en;
          if (rx_en && !skip_q) begin
            state_q   <= RECV;
            byteCnt_q <= 16'd1;
            if (whereis_aux == 0) aux_q <= rx_data;
          end
        end
        RECV: begin
          if (rx_en) begin
            if (byteCnt_q != 16'hFFFF) byteCnt_q <= byteCnt_q + 16'd1;
            if (byteCnt_q == AUX_IDX) aux_q <= rx_data;
          end else begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          if (byteCnt_q > AUX_IDX) begin
            count_q <= count_q + 32'd1;
            if (!haveGroup_q) begin
              curAux_q      <= aux_q;
              segCnt_q      <= 16'd1;
              groupOpen_q   <= 1'b1;
              haveGroup_q   <= 1'b1;
              judgeChange_q <= 1'b0;
              if (maxEff == 16'd1) state_q <= JUDGE;
            end else if (!sameAux) begin
              judgeChange_q <= 1'b1;
              state_q       <= JUDGE;
            end else if (groupOpen_q) begin
              segCnt_q      <= segInc;
              judgeChange_q <= 1'b0;
              if (segInc == maxEff) state_q <= JUDGE;
            end
          end
        end
        JUDGE: begin
          state_q <= IDLE;
          if (!judgeChange_q) begin
            ok_q        <= ok_q + 32'd1;
            groupOpen_q <= 1'b0;
            valid_q     <= 1'b1;
          end else begin
            if (groupOpen_q) begin
              ng_q      <= ng_q + 32'd1;
              lostnum_q <= lostnum_q + {16'd0, lostInc};
              valid_q   <= 1'b1;
            end
            curAux_q    <= aux_q;
            segCnt_q    <= 16'd1;
            groupOpen_q <= 1'b1;
            // A one-frame group is already complete the moment it opens.
            if (maxEff == 16'd1) begin
              ok_q        <= ok_q + 32'd1;
              groupOpen_q <= 1'b0;
              valid_q     <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count   = count_q;
  assign ok      = ok_q;
  assign ng      = ng_q;
  assign lostnum = lostnum_q;
  assign valid   = valid_q;
  assign state   = state_q;

endmodule

// File: tb/tb_detect_errors.sv
// Randomized bench for detect_errors: two instances (aux at byte 0 and byte 5)
// checked against a frame-level reference model of the group rules.
module tb_detect_errors;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] max0, max5;
  logic        en0, en5;
  logic [7:0]  data0, data5;
  logic [31:0] cnt0, ok0, ng0, lost0, cnt5, ok5, ng5, lost5;
  logic        valid0, valid5;
  logic [2:0]  state0, state5;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mCnt[2], mOk[2], mNg[2], mLost[2], mEv[2], validCycles[2];
  logic [7:0]  mCur[2];
  int          mSegs[2];
  bit          mOpen[2], mHave[2];

  always #4 clk = ~clk;

  detect_errors #(.whereis_aux(0)) dut0 (
    .clk(clk), .rst(rst), .segment_number_max(max0), .rx_en(en0), .rx_data(data0),
    .count(cnt0), .ok(ok0), .ng(ng0), .lostnum(lost0), .valid(valid0), .state(state0)
  );

  detect_errors #(.whereis_aux(5)) dut5 (
    .clk(clk), .rst(rst), .segment_number_max(max5), .rx_en(en5), .rx_data(data5),
    .count(cnt5), .ok(ok5), .ng(ng5), .lostnum(lost5), .valid(valid5), .state(state5)
  );

  always @(negedge clk) begin
    if (valid0) validCycles[0] <= validCycles[0] + 32'd1;
    if (valid5) validCycles[1] <= validCycles[1] + 32'd1;
  end

  function automatic int auxPos(input int d);
    return (d == 0) ? 0 : 5;
  endfunction

  function automatic int effMax(input int d);
    int m;
    m = (d == 0) ? int'(max0) : int'(max5);
    return (m == 0) ? 1 : m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int d = 0; d < 2; d++) begin
      mCnt[d] = 0; mOk[d] = 0; mNg[d] = 0; mLost[d] = 0; mEv[d] = 0;
      mCur[d] = 0; mSegs[d] = 0; mOpen[d] = 0; mHave[d] = 0;
    end
  endtask

  // Group bookkeeping at frame granularity: one call per received frame.
  task automatic modelFrame(input int d, input int len, input logic [7:0] aux);
    int m;
    bit ev;
    m  = effMax(d);
    ev = 0;
    if (len < auxPos(d) + 1) return;
    mCnt[d]++;
    if (!mHave[d] || aux != mCur[d]) begin
      if (mHave[d] && mOpen[d]) begin
        mNg[d]++;
        mLost[d] = mLost[d] + 32'(m - mSegs[d]);
        ev = 1;
      end
      mHave[d] = 1; mCur[d] = aux; mSegs[d] = 1; mOpen[d] = 1;
      if (mSegs[d] == m) begin mOk[d]++; mOpen[d] = 0; ev = 1; end
    end else if (mOpen[d]) begin
      mSegs[d]++;
      if (mSegs[d] == m) begin mOk[d]++; mOpen[d] = 0; ev = 1; end
    end
    if (ev) mEv[d]++;
  endtask

  task automatic applyStimulus(input int d, input int len, input logic [7:0] aux, input int gap);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      b = (i == auxPos(d)) ? aux : 8'($urandom);
      if (d == 0) begin en0 = 1'b1; data0 = b; end
      else        begin en5 = 1'b1; data5 = b; end
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (d == 0) begin en0 = 1'b0; data0 = 8'($urandom); end
      else        begin en5 = 1'b0; data5 = 8'($urandom); end
    end
    modelFrame(d, len, aux);
  endtask

  task automatic checkAll(input int d);
    string p;
    @(negedge clk);
    #1;
    p = (d == 0) ? "d0" : "d5";
    checkOutput({p, ".count"},   (d == 0) ? cnt0  : cnt5,  mCnt[d]);
    checkOutput({p, ".ok"},      (d == 0) ? ok0   : ok5,   mOk[d]);
    checkOutput({p, ".ng"},      (d == 0) ? ng0   : ng5,   mNg[d]);
    checkOutput({p, ".lostnum"}, (d == 0) ? lost0 : lost5, mLost[d]);
    checkOutput({p, ".validCycles"}, validCycles[d], mEv[d]);
    checkOutput({p, ".state"}, 32'((d == 0) ? state0 : state5), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    validCycles[0] = 0;
    validCycles[1] = 0;
    modelClear();
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] prevAux;
    rst = 1'b1; en0 = 1'b0; en5 = 1'b0; data0 = 8'd0; data5 = 8'd0;
    max0 = 16'd50; max5 = 16'd3;
    validCycles[0] = 0; validCycles[1] = 0;
    modelClear();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst.valid0", 32'(valid0), 32'd0);
    checkOutput("rst.valid5", 32'(valid5), 32'd0);
    rst = 1'b0;
    checkAll(0);
    checkAll(1);

    // Long run: 270 groups of 50, aux wrapping 255->0, group 12 loses 2 frames.
    for (int g = 0; g < 270; g++) begin
      a = 8'(g);
      for (int f = 0; f < 50; f++) begin
        if (g == 12 && (f == 7 || f == 8)) continue;
        if (g < 4) applyStimulus(0, 33, a, 10);
        else       applyStimulus(0, 1, a, 3);
        if (g == 13 && f == 0) begin
          checkAll(0);
          checkOutput("loss.ng", ng0, 32'd1);
          checkOutput("loss.lostnum", lost0, 32'd2);
          checkOutput("loss.ok", ok0, 32'd12);
        end
      end
      if (g == 3) begin
        checkAll(0);
        checkOutput("clean.count", cnt0, 32'd200);
        checkOutput("clean.ok", ok0, 32'd4);
        checkOutput("clean.validCycles", validCycles[0], 32'd4);
      end else if (g % 16 == 0 || g >= 250) begin
        checkAll(0);
      end
    end
    checkAll(0);
    checkOutput("full.count", cnt0, 32'd13498);
    checkOutput("full.ok", ok0, 32'd269);
    checkOutput("full.ng", ng0, 32'd1);
    checkOutput("full.lostnum", lost0, 32'd2);

    doReset();
    checkAll(0);

    // Reset in the middle of a frame: the remainder must be ignored.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); en0 = 1'b1; data0 = 8'h77;
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    #1;
    validCycles[0] = 0;
    modelClear();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); en0 = 1'b1; data0 = 8'h55;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); en0 = 1'b0;
    end
    checkAll(0);
    checkOutput("midrst.count", cnt0, 32'd0);

    for (int f = 0; f < 50; f++) applyStimulus(0, $urandom_range(1, 8), 8'h40, 3);
    checkAll(0);
    checkOutput("regroup.ok", ok0, 32'd1);
    checkOutput("regroup.count", cnt0, 32'd50);
    applyStimulus(0, 4, 8'h40, 3);
    checkAll(0);
    checkOutput("dup.count", cnt0, 32'd51);
    checkOutput("dup.ok", ok0, 32'd1);
    checkOutput("dup.validCycles", validCycles[0], 32'd1);

    // Aux at byte 5: a 3-byte frame is too short to carry a tag.
    max5 = 16'd3;
    doReset();
    applyStimulus(1, 3, 8'hA1, 3);
    checkAll(1);
    checkOutput("short.count", cnt5, 32'd0);

    for (int r = 0; r < 5; r++) begin
      max5 = 16'($urandom_range(0, 4));
      doReset();
      prevAux = 8'hA0;
      for (int f = 0; f < 40; f++) begin
        if ($urandom_range(0, 2) == 0) prevAux = 8'hA0 + 8'($urandom_range(0, 2));
        applyStimulus(1, $urandom_range(1, 10), prevAux, $urandom_range(3, 5));
        checkAll(1);
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/detect_errors.md
Name: detect_errors

Overview:
- Receive-side frame-loss checker; sits after the Ethernet RX byte stream (rx_en/rx_data, one byte per clk).
- Each frame carries an 8-bit sequence tag ("aux") at a fixed byte offset. A sender transmits segment_number_max frames per aux value, then moves to a new aux value.
- The block counts received frames and judges each aux group complete (ok) or short (ng), and accumulates the number of missing frames (lostnum).

Parameters:
- whereis_aux, default 0: byte index within the frame (0 = first byte with rx_en high) that holds the aux tag.

Ports:
- clk  input  1  system clock (125 MHz), all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- segment_number_max  input  16  expected frames per aux group; quasi-static; 0 is treated as 1
- rx_en  input  1  frame-valid; high for the whole frame, low between frames
- rx_data  input  8  frame byte, valid only while rx_en=1 (X otherwise, must be ignored)
- count  output  32  total accepted frames since reset
- ok  output  32  number of groups judged complete
- ng  output  32  number of groups judged short
- lostnum  output  32  accumulated missing frames
- valid  output  1  one-cycle pulse when ok/ng/lostnum has just been updated
- state  output  3  current FSM state encoding

Behaviour:
- Reset (async, rst=1): count=ok=ng=lostnum=0, valid=0, state=IDLE. Internal byte counter, aux latch, cur_aux, seg_cnt, group_open, have_group are all cleared. Reset mid-frame abandons the frame; the remainder of that frame is ignored until rx_en goes low.
- FSM encoding: IDLE=0, RECV=1, CHECK=2, JUDGE=3. Codes 4-7 are unused and return to IDLE.
- IDLE:
  - rx_en=1 -> RECV, byte counter=1.
  - If whereis_aux=0, latch rx_data as aux on this edge.
- RECV:
  - Each cycle with rx_en=1, increment the byte counter (16-bit, saturating).
  - Latch aux when the counter equals whereis_aux.
  - rx_en=0 -> CHECK.
- CHECK (one cycle):
  - Frame shorter than whereis_aux+1 bytes -> discard, no counter change -> IDLE.
  - Otherwise count += 1, then:
    - No group yet (have_group=0): cur_aux=aux, seg_cnt=1, group_open=1, have_group=1.
    - aux == cur_aux and group_open: seg_cnt += 1.
    - aux == cur_aux and group already closed: ignored beyond count.
    - aux != cur_aux: -> JUDGE.
  - After updating seg_cnt: if seg_cnt reaches segment_number_max -> JUDGE (completion); else -> IDLE.
- JUDGE (one cycle), exactly one of:
  - Completion (seg_cnt == max): ok += 1, group_open=0.
  - aux change with group_open: ng += 1, lostnum += (max - seg_cnt), then start new group: cur_aux=aux, seg_cnt=1, group_open=1. If max=1 the new group is also completed (ok += 1) on this edge.
  - aux change with group closed: no judge update, start new group as above.
- valid: registered; high exactly one cycle, on the cycle after any edge that changed ok/ng/lostnum. Otherwise 0.
- JUDGE -> IDLE. A new frame starting while in CHECK/JUDGE (min inter-frame gap < 2 cycles) is not supported.
- Aux compare is pure 8-bit inequality; wrap 255->0 is a normal change.
- seg_cnt never exceeds max while open. The last group stays pending (open) until another aux arrives.
- All 32-bit counters wrap modulo 2^32.

Test Plan:
- Reset: rst pulse -> all outputs 0, state=0, valid=0.
- Clean run, whereis_aux=0, 33-byte frames (aux byte then 0x12 x32), max=50, aux 0..3 x 50 frames each, 10-cycle gaps -> count=200, ok=4, ng=0, lostnum=0, four single-cycle valid pulses.
- Loss: aux 12 group missing its 8th and 9th frames, then aux 13 group -> ng=1, lostnum=2, ok unchanged for group 12. Full 270-group sequence (aux wraps 255->0..13) -> before final reset count=13498, ok=269, ng=1, lostnum=2.
- Short frame: whereis_aux=5, 3-byte frame -> count unchanged, state returns to 0.
- Mid-operation reset: after the 270-group run, rst pulse -> all counters 0; next clean group of 50 -> ok=1, count=50.
- Duplicate after completion: 51st frame with the same aux -> count+1, ok/ng/lostnum unchanged, no valid pulse.
